// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing for the five-stage MIPS core: register enables/flushes, PC enable,
// memory-wait stalls, load-use bubbles, branch/jump flushes and the halt drain.
//   state  | meaning
//   RUN    | normal issue
//   DRAIN  | halt fetched, front end frozen, back end empties
//   HALTED | terminal until nRST
module pipeline_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_mem,
  input  logic             dmemWEN_mem,
  input  logic             memread_ex,
  input  logic [REG_W-1:0] wsel_ex,
  input  logic [REG_W-1:0] rs_id,
  input  logic [REG_W-1:0] rt_id,
  input  logic             branch_taken_ex,
  input  logic             jump_id,
  input  logic             halt_id,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           r_state;
  logic             r_halt;
  logic [CNT_W-1:0] r_stall;

  logic w_dreq;
  logic w_adv;
  logic w_load_use;
  logic w_bubble;

  assign w_dreq     = dmemREN_mem | dmemWEN_mem;
  assign w_load_use = memread_ex && (wsel_ex != '0) &&
                      ((wsel_ex == rs_id) || (wsel_ex == rt_id));

  always_comb begin
    w_adv = 1'b0;
    case (r_state)
      RUN:     w_adv = w_dreq ? dhit : ihit;
      DRAIN:   w_adv = w_dreq ? dhit : 1'b1;
      default: w_adv = 1'b0;
    endcase
  end

  assign w_bubble = (r_state == RUN) && w_adv && !branch_taken_ex && w_load_use;

  // Gated by nRST so every enable/flush is low for the whole reset window.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (nRST && w_adv) begin
      exmem_en = 1'b1;
      memwb_en = 1'b1;
      if (r_state == RUN) begin
        if (branch_taken_ex) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          idex_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (w_load_use) begin
          idex_flush = 1'b1;
        end else begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          idex_en    = 1'b1;
          ifid_flush = jump_id | halt_id;
        end
      end else begin
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
      r_halt  <= 1'b0;
      r_stall <= '0;
    end else begin
      if (r_state != HALTED && w_adv && halt_wb) begin
        r_state <= HALTED;
        r_halt  <= 1'b1;
      end else if (r_state == RUN && w_adv && !branch_taken_ex && !w_load_use &&
                   !jump_id && halt_id) begin
        r_state <= DRAIN;
      end
      if (r_state != HALTED && (!w_adv || w_bubble) && (r_stall != '1))
        r_stall <= r_stall + 1'b1;
    end
  end

  assign halt         = r_halt;
  assign stall_cycles = r_stall;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table for RUN-state decode plus
// hand-written stall, branch-under-stall, halt drain, async reset and saturation sequences.
module tb_pipeline_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic ihit, dhit, dmemREN_mem, dmemWEN_mem, memread_ex;
  logic [REG_W-1:0] wsel_ex, rs_id, rt_id;
  logic branch_taken_ex, jump_id, halt_id, halt_wb;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, halt;
  logic [CNT_W-1:0] stall_cycles;
  logic [7:0] outs;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dmemREN_mem(dmemREN_mem), .dmemWEN_mem(dmemWEN_mem),
    .memread_ex(memread_ex), .wsel_ex(wsel_ex), .rs_id(rs_id), .rt_id(rt_id),
    .branch_taken_ex(branch_taken_ex), .jump_id(jump_id),
    .halt_id(halt_id), .halt_wb(halt_wb),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .halt(halt), .stall_cycles(stall_cycles)
  );

  // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl}
  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush};

  typedef struct packed {
    logic             ihit;
    logic             dhit;
    logic             ren;
    logic             wen;
    logic             mrd;
    logic [REG_W-1:0] wsel;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             br;
    logic             jmp;
    logic [7:0]       exp;
    logic             inc;
  } vec_t;

  localparam logic [7:0] ALL_EN = 8'b11111_000;
  localparam logic [7:0] NONE   = 8'b00000_000;
  localparam logic [7:0] LU     = 8'b00011_010;
  localparam logic [7:0] BR     = 8'b11111_110;
  localparam logic [7:0] JMP    = 8'b11111_100;
  localparam logic [7:0] DRN    = 8'b00011_010;

  int n_tot = 0;
  int n_pass = 0;
  logic [CNT_W-1:0] exp_stall;
  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_in();
    ihit = 1'b0; dhit = 1'b0; dmemREN_mem = 1'b0; dmemWEN_mem = 1'b0;
    memread_ex = 1'b0; wsel_ex = '0; rs_id = '0; rt_id = '0;
    branch_taken_ex = 1'b0; jump_id = 1'b0; halt_id = 1'b0; halt_wb = 1'b0;
  endtask

  initial begin
    clear_in();
    vecs[0]  = '{1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, ALL_EN, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NONE,   1};
    vecs[2]  = '{1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NONE,   1};
    vecs[3]  = '{0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, ALL_EN, 0};
    vecs[4]  = '{1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, NONE,   1};
    vecs[5]  = '{1, 0, 0, 0, 1, 5'd2, 5'd2, 5'd9, 0, 0, LU,     1};
    vecs[6]  = '{1, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0, LU,     1};
    vecs[7]  = '{1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, ALL_EN, 0};
    vecs[8]  = '{1, 0, 0, 0, 0, 5'd2, 5'd2, 5'd2, 0, 0, ALL_EN, 0};
    vecs[9]  = '{1, 0, 0, 0, 1, 5'd3, 5'd4, 5'd5, 0, 0, ALL_EN, 0};
    vecs[10] = '{1, 0, 0, 0, 1, 5'd2, 5'd2, 5'd0, 1, 0, BR,     0};
    vecs[11] = '{1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, JMP,    0};
    vecs[12] = '{1, 0, 0, 0, 1, 5'd6, 5'd0, 5'd6, 0, 1, LU,     1};
    vecs[13] = '{0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, 1, NONE,   1};
    vecs[14] = '{0, 0, 0, 0, 1, 5'd2, 5'd2, 5'd0, 0, 0, NONE,   1};

    // Reset window: outputs forced low even with ihit asserted
    ihit = 1'b1;
    #12;
    check("reset_outs", 32'(outs), 32'(NONE));
    check("reset_halt", 32'(halt), 32'd0);
    check("reset_stall", 32'(stall_cycles), 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    exp_stall = '0;

    for (int i = 0; i < 15; i++) begin
      ihit = vecs[i].ihit; dhit = vecs[i].dhit;
      dmemREN_mem = vecs[i].ren; dmemWEN_mem = vecs[i].wen;
      memread_ex = vecs[i].mrd; wsel_ex = vecs[i].wsel;
      rs_id = vecs[i].rs; rt_id = vecs[i].rt;
      branch_taken_ex = vecs[i].br; jump_id = vecs[i].jmp;
      #2;
      check($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].exp));
      @(posedge CLK); #1;
      exp_stall = exp_stall + CNT_W'(vecs[i].inc);
      check($sformatf("vec%0d_stall", i), 32'(stall_cycles), 32'(exp_stall));
    end

    // Data wait: four stalled cycles then dhit
    clear_in();
    ihit = 1'b1; dmemREN_mem = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2 check($sformatf("dwait%0d_outs", i), 32'(outs), 32'(NONE));
      @(posedge CLK); #1;
    end
    dhit = 1'b1;
    #2 check("dwait_release_outs", 32'(outs), 32'(ALL_EN));
    @(posedge CLK); #1;
    exp_stall = exp_stall + CNT_W'(4);
    check("dwait_stall", 32'(stall_cycles), 32'(exp_stall));

    // Branch held across a data wait: flush only when dhit arrives
    clear_in();
    ihit = 1'b1; branch_taken_ex = 1'b1; dmemWEN_mem = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2 check($sformatf("brwait%0d_outs", i), 32'(outs), 32'(NONE));
      @(posedge CLK); #1;
    end
    dhit = 1'b1;
    #2 check("brwait_release_outs", 32'(outs), 32'(BR));
    @(posedge CLK); #1;
    exp_stall = exp_stall + CNT_W'(2);
    check("brwait_stall", 32'(stall_cycles), 32'(exp_stall));

    // Halt: decode, three drain cycles (ihit low, a branch ignored), then halt_wb
    clear_in();
    ihit = 1'b1; halt_id = 1'b1;
    #2 check("halt_id_outs", 32'(outs), 32'(JMP));
    @(posedge CLK); #1;
    clear_in();
    for (int i = 0; i < 3; i++) begin
      branch_taken_ex = (i == 1);
      halt_wb = (i == 2);
      #2 check($sformatf("drain%0d_outs", i), 32'(outs), 32'(DRN));
      check($sformatf("drain%0d_halt", i), 32'(halt), 32'd0);
      @(posedge CLK); #1;
    end
    clear_in();
    ihit = 1'b1; dhit = 1'b1;
    #2;
    check("halted_halt", 32'(halt), 32'd1);
    check("halted_outs", 32'(outs), 32'(NONE));
    check("halted_stall", 32'(stall_cycles), 32'(exp_stall));
    @(posedge CLK); #1;
    check("halted_stall_hold", 32'(stall_cycles), 32'(exp_stall));

    // Asynchronous reset mid-cycle
    #2 nRST = 1'b0;
    #1;
    check("async_rst_halt", 32'(halt), 32'd0);
    check("async_rst_stall", 32'(stall_cycles), 32'd0);
    check("async_rst_outs", 32'(outs), 32'(NONE));
    @(posedge CLK); #1;
    nRST = 1'b1;
    #2 check("post_rst_run_outs", 32'(outs), 32'(ALL_EN));

    // Saturation: 2^16 + 5 stalled edges
    @(posedge CLK); #1;
    dmemREN_mem = 1'b1; dhit = 1'b0;
    repeat ((1 << CNT_W) + 5) @(posedge CLK);
    #1 check("stall_saturate", 32'(stall_cycles), 32'h0000_FFFF);
    @(posedge CLK); #1;
    check("stall_saturate_hold", 32'(stall_cycles), 32'h0000_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencing unit for the five-stage MIPS pipeline.
- Generates per-register enable/flush for IF_ID, ID_EX, EX_MEM and MEM_WB, plus the PC enable.
- Resolves i/d memory wait stalls, load-use bubbles, branch/jump flushes and the halt drain sequence.
- Sits beside the datapath, consuming hit signals from the cache/memory controller and hazard fields from the pipeline registers.

Parameters:
REG_W, 5, register-select width (wsel/rs/rt)
CNT_W, 16, width of saturating stall-cycle counter

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  reset, asynchronous, active-low
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
dmemREN_mem  in  1  MEM-stage instruction is a load
dmemWEN_mem  in  1  MEM-stage instruction is a store
memread_ex  in  1  EX-stage instruction is a load
wsel_ex  in  REG_W  EX-stage destination register
rs_id  in  REG_W  ID-stage source rs
rt_id  in  REG_W  ID-stage source rt
branch_taken_ex  in  1  EX-stage branch resolved taken
jump_id  in  1  ID-stage J/JAL/JR
halt_id  in  1  ID-stage HALT decoded
halt_wb  in  1  HALT present at MEM_WB output
pc_en  out  1  PC register update
ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register load enables
ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous clear-to-bubble on next edge
halt  out  1  processor halted (registered)
stall_cycles  out  CNT_W  count of non-advancing/bubble cycles

Behaviour:
- Clock and reset: one clock CLK; reset nRST asynchronous, active-low.
- While nRST=0:
  - state=RUN, halt=0, stall_cycles=0.
  - All *_en and *_flush forced 0.
- States:
  - RUN: normal operation.
  - DRAIN: halt fetched; front end frozen.
  - HALTED: terminal until reset.
- dreq = dmemREN_mem | dmemWEN_mem.
- adv: in RUN = dreq ? dhit : ihit; in DRAIN = dreq ? dhit : 1; in HALTED = 0.
- adv=0 (memory stall): all enables 0, all flushes 0. Flush conditions persist because the registers are frozen, so they are acted on when adv rises.
- With adv=1, in RUN, apply in priority order:
  1. branch_taken_ex: pc_en=1 (loads target); ifid_flush=1, idex_flush=1; exmem_en=memwb_en=1. Overrides load-use and jump.
  2. Load-use:
     - Condition: memread_ex & wsel_ex!=0 & (wsel_ex==rs_id | wsel_ex==rt_id).
     - Response: pc_en=0, ifid_en=0, idex_flush=1 (bubble), exmem_en=memwb_en=1.
  3. jump_id: all en=1, ifid_flush=1.
  4. halt_id: all en=1, ifid_flush=1, next state DRAIN.
  5. Otherwise: all en=1, no flush.
- Load-use bubble lasts exactly one cycle: the next cycle has memread_ex=0 from the bubble.
- DRAIN:
  - pc_en=0, ifid_en=0, idex_flush=1 (bubbles).
  - exmem_en, memwb_en = adv; ihit ignored.
  - A branch_taken_ex in DRAIN is ignored, since the halt is younger than the branch only if the branch was already resolved.
- Any state, halt_wb=1 with adv: next state HALTED, halt<=1 on that edge.
- HALTED: all outputs 0 except halt=1 and stall_cycles holding.
- exmem_flush is reserved: always 0 in this revision, present for exception support.
- memwb_en = adv in every non-HALTED state. This is the hit-qualified MEM_WB load.
- stall_cycles:
  - +1 on each edge in RUN/DRAIN where adv=0 or a load-use bubble is inserted.
  - Saturates at all-ones; no wrap.
- Reset mid-stall or mid-drain: immediate return to RUN values above; no residual flush.

Test Plan:
- Load-use: lw $2 in EX (memread_ex=1, wsel_ex=2), rs_id=2, ihit=1 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; next cycle all en=1; stall_cycles=1.
- wsel_ex=0 with rs_id=0, memread_ex=1 -> no bubble, all en=1, stall_cycles unchanged.
- dreq=1, dhit low for 4 cycles then high -> all en=0 for 4 cycles, all en=1 on the 5th; stall_cycles=4.
- branch_taken_ex=1 coinciding with the load-use condition and adv=1 -> ifid_flush=1, idex_flush=1, pc_en=1, no stall increment.
- branch_taken_ex=1 with dreq=1, dhit=0 for 2 cycles -> no flush while stalled; flushes asserted on the cycle dhit=1.
- halt_id, then halt_wb 3 cycles later -> DRAIN with pc_en=0 for 3 cycles; halt=1 after the edge with halt_wb; all en=0 thereafter; nRST low clears halt to 0 asynchronously.
- Force 2^CNT_W+5 stall cycles -> stall_cycles holds 0xFFFF.
